fifo_write_gen: RTL

FIFO_WRITE_GEN -- requirements
Module: fifo_write_gen

---
 rtl/fifo_write_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_write_gen.sv
// rtl/fifo_write_gen.sv - burst write generator that refills a FIFO after almost_empty rises
// Data counts 0,1,2... per burst and stalls on full. The burst ends when almost_full is seen.
module fifo_write_gen #(
    parameter int DELAY_CYCLES = 10,
    parameter int DATA_W       = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              almost_empty,
    input  logic              almost_full,
    input  logic              full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              busy,
    output logic [7:0]        burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [3:0] DLY_LAST = 4'(DELAY_CYCLES);

    state_t              state_q, state_d;
    logic                ae_d0_q, ae_d1_q;
    logic [3:0]          dcnt_q, dcnt_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          burst_q, burst_d;
    logic                start;

    assign start      = ae_d0_q & ~ae_d1_q;
    assign fifo_wr_en = wr_q & ~full;
    assign fifo_wdata = data_q;
    assign busy       = (state_q != S_IDLE);
    assign burst_cnt  = burst_q;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wr_d    = wr_q;
        data_d  = data_q;
        burst_d = burst_q;

        // Advance only on an actual write so a full stall never skips a value.
        if (fifo_wr_en) begin
            data_d = data_q + DATA_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (dcnt_q == DLY_LAST) begin
                    dcnt_d  = 4'd0;
                    wr_d    = 1'b1;
                    data_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            S_WRITE: begin
                if (almost_full) begin
                    wr_d    = 1'b0;
                    burst_d = burst_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
                dcnt_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            ae_d0_q <= 1'b0;
            ae_d1_q <= 1'b0;
            dcnt_q  <= 4'd0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            ae_d0_q <= almost_empty;
            ae_d1_q <= ae_d0_q;
            dcnt_q  <= dcnt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            burst_q <= burst_d;
        end
    end

endmodule
